// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with its IF/ID pipeline register.
// Holds the fetch PC and keeps at most one request outstanding on an
// SRAM-like instruction bus (req / addr_ok / data_ok). Decode supplies
// branch redirects and delay-slot tags. The exception unit supplies
// flush/redirect. A misaligned fetch PC is reported as an address
// exception and never reaches the bus.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_to_addr_i,
    input  logic        next_is_in_delayslot_i,
    output logic        inst_req_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_addr_ok_i,
    input  logic        inst_data_ok_i,
    input  logic [31:0] inst_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        is_in_delayslot_o,
    output logic        addr_exception_o,
    output logic        valid_o
);

    typedef enum logic [1:0] {
        S_REQ,      // presenting fetch_pc on the bus
        S_WAIT,     // address accepted, waiting for data
        S_HOLD,     // data captured while decode was stalled
        S_DISCARD   // flushed while a response is outstanding: drop it
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        redir_pending_q, redir_pending_d;
    logic [31:0] redir_target_q, redir_target_d;
    logic        ds_pending_q, ds_pending_d;
    logic [31:0] hold_inst_q, hold_inst_d;

    // IF/ID register
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        ds_q, ds_d;
    logic        exc_q, exc_d;
    logic        valid_q, valid_d;

    logic        misaligned;
    logic        deliver;
    logic        deliver_exc;
    logic [31:0] deliver_inst;

    assign misaligned  = (fetch_pc_q[1:0] != 2'b00);
    assign inst_req_o  = rst && (state_q == S_REQ) && !misaligned;
    assign inst_addr_o = fetch_pc_q;

    assign pc_o              = pc_q;
    assign inst_o            = inst_q;
    assign is_in_delayslot_o = ds_q;
    assign addr_exception_o  = exc_q;
    assign valid_o           = valid_q;

    // Next-state logic: bus FSM, fetch PC selection and IF/ID load.
    always_comb begin
        // NOTE: every variable gets a default here so no path can infer a latch.
        state_d         = state_q;
        fetch_pc_d      = fetch_pc_q;
        redir_pending_d = redir_pending_q;
        redir_target_d  = redir_target_q;
        ds_pending_d    = ds_pending_q;
        hold_inst_d     = hold_inst_q;
        pc_d            = pc_q;
        inst_d          = inst_q;
        ds_d            = ds_q;
        exc_d           = exc_q;
        valid_d         = valid_q;
        deliver         = 1'b0;
        deliver_exc     = 1'b0;
        deliver_inst    = NOP_INST;

        // Bus handshake. data_ok counts only in WAIT and DISCARD. A stale
        // response seen in REQ or HOLD is ignored.
        case (state_q)
            S_REQ: begin
                if (misaligned) begin
                    if (!stall_i) begin
                        deliver     = 1'b1;
                        deliver_exc = 1'b1;
                    end
                end else if (inst_addr_ok_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (inst_data_ok_i) begin
                    if (!stall_i) begin
                        deliver      = 1'b1;
                        deliver_inst = inst_rdata_i;
                        state_d      = S_REQ;
                    end else begin
                        hold_inst_d = inst_rdata_i;
                        state_d     = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (!stall_i) begin
                    deliver      = 1'b1;
                    deliver_inst = hold_inst_q;
                    state_d      = S_REQ;
                end
            end
            S_DISCARD: begin
                if (inst_data_ok_i) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase

        // IF/ID advances only when decode consumes. The branch currently in
        // ID picks the PC that follows the delivered instruction. If nothing
        // is delivered, a consumed branch is remembered for the next delivery.
        if (!stall_i) begin
            if (deliver) begin
                pc_d    = fetch_pc_q;
                inst_d  = deliver_inst;
                ds_d    = (valid_q && next_is_in_delayslot_i) || ds_pending_q;
                exc_d   = deliver_exc;
                valid_d = 1'b1;
                if (valid_q && branch_flag_i) begin
                    fetch_pc_d = branch_to_addr_i;
                end else if (redir_pending_q) begin
                    fetch_pc_d = redir_target_q;
                end else begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                end
                redir_pending_d = 1'b0;
                ds_pending_d    = 1'b0;
            end else begin
                inst_d  = NOP_INST;
                ds_d    = 1'b0;
                exc_d   = 1'b0;
                valid_d = 1'b0;
                if (valid_q) begin
                    if (branch_flag_i) begin
                        redir_pending_d = 1'b1;
                        redir_target_d  = branch_to_addr_i;
                    end
                    if (next_is_in_delayslot_i) begin
                        ds_pending_d = 1'b1;
                    end
                end
            end
        end

        // A flush overrides everything above. A response that is already
        // promised by the bus must still be drained, which is the job of
        // DISCARD.
        if (flush_i) begin
            fetch_pc_d      = flush_pc_i;
            redir_pending_d = 1'b0;
            ds_pending_d    = 1'b0;
            pc_d            = pc_q;
            inst_d          = NOP_INST;
            ds_d            = 1'b0;
            exc_d           = 1'b0;
            valid_d         = 1'b0;
            case (state_q)
                S_REQ:     state_d = (!misaligned && inst_addr_ok_i) ? S_DISCARD : S_REQ;
                S_WAIT:    state_d = inst_data_ok_i ? S_REQ : S_DISCARD;
                S_HOLD:    state_d = S_REQ;
                S_DISCARD: state_d = inst_data_ok_i ? S_REQ : S_DISCARD;
                default:   state_d = S_REQ;
            endcase
        end
    end

    // Control state and IF/ID register, synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            state_q         <= S_REQ;
            fetch_pc_q      <= RESET_PC;
            redir_pending_q <= 1'b0;
            ds_pending_q    <= 1'b0;
            pc_q            <= 32'h0000_0000;
            inst_q          <= NOP_INST;
            ds_q            <= 1'b0;
            exc_q           <= 1'b0;
            valid_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            fetch_pc_q      <= fetch_pc_d;
            redir_pending_q <= redir_pending_d;
            ds_pending_q    <= ds_pending_d;
            pc_q            <= pc_d;
            inst_q          <= inst_d;
            ds_q            <= ds_d;
            exc_q           <= exc_d;
            valid_q         <= valid_d;
        end
    end

    // Data-only registers: hold buffer and pending redirect target.
    always_ff @(posedge clk) begin
        // NOTE: no reset here; these are read only when HOLD or redir_pending_q qualifies them.
        hold_inst_q    <= hold_inst_d;
        redir_target_q <= redir_target_d;
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage. The stimulus drives the bus and
// decode inputs cycle by cycle and queues each delivery it expects. A
// monitor pops the queue whenever IF/ID loads a valid instruction.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic        branch_flag_i;
    logic [31:0] branch_to_addr_i;
    logic        next_is_in_delayslot_i;
    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_addr_ok_i;
    logic        inst_data_ok_i;
    logic [31:0] inst_rdata_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        is_in_delayslot_o;
    logic        addr_exception_o;
    logic        valid_o;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        ds;
        logic        exc;
    } exp_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] tgt;
        logic        stall_a;
        logic        br_a;
        logic        ds_a;
        logic        br_b;
        logic        ds_b;
        logic        exp_ds;
    } fetch_vec_t;

    exp_t sb[$];

    if_fetch_stage dut (
        .clk                    (clk),
        .rst                    (rst),
        .stall_i                (stall_i),
        .flush_i                (flush_i),
        .flush_pc_i             (flush_pc_i),
        .branch_flag_i          (branch_flag_i),
        .branch_to_addr_i       (branch_to_addr_i),
        .next_is_in_delayslot_i (next_is_in_delayslot_i),
        .inst_req_o             (inst_req_o),
        .inst_addr_o            (inst_addr_o),
        .inst_addr_ok_i         (inst_addr_ok_i),
        .inst_data_ok_i         (inst_data_ok_i),
        .inst_rdata_i           (inst_rdata_i),
        .pc_o                   (pc_o),
        .inst_o                 (inst_o),
        .is_in_delayslot_o      (is_in_delayslot_o),
        .addr_exception_o       (addr_exception_o),
        .valid_o                (valid_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic fetch_vec_t fv(input logic [31:0] pc, input logic [31:0] inst,
                                      input logic stall_a, input logic br_a, input logic ds_a,
                                      input logic br_b, input logic ds_b,
                                      input logic [31:0] tgt, input logic exp_ds);
        fetch_vec_t v;
        v.pc = pc; v.inst = inst; v.tgt = tgt;
        v.stall_a = stall_a; v.br_a = br_a; v.ds_a = ds_a;
        v.br_b = br_b; v.ds_b = ds_b; v.exp_ds = exp_ds;
        return v;
    endfunction

    task automatic idle();
        @(negedge clk);
        stall_i = 1'b0; flush_i = 1'b0; branch_flag_i = 1'b0; next_is_in_delayslot_i = 1'b0;
        inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b0;
    endtask

    // Two-cycle fetch: address accepted in cycle a, data returned in cycle b.
    task automatic fetch(input fetch_vec_t v);
        exp_t e;
        @(negedge clk);
        stall_i = v.stall_a; branch_flag_i = v.br_a; next_is_in_delayslot_i = v.ds_a;
        branch_to_addr_i = v.tgt; flush_i = 1'b0;
        inst_addr_ok_i = 1'b1; inst_data_ok_i = 1'b0;
        #1;
        check("req_a", {31'd0, inst_req_o}, 32'd1);
        check("addr_a", inst_addr_o, v.pc);
        @(negedge clk);
        stall_i = 1'b0; branch_flag_i = v.br_b; next_is_in_delayslot_i = v.ds_b;
        inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b1; inst_rdata_i = v.inst;
        e.pc = v.pc; e.inst = v.inst; e.ds = v.exp_ds; e.exc = 1'b0;
        sb.push_back(e);
        #1;
        check("req_b", {31'd0, inst_req_o}, 32'd0);
    endtask

    // Monitor: IF/ID loaded at this edge; a valid result must match the queue head.
    always @(posedge clk) begin
        logic ld;
        exp_t e;
        ld = rst && !stall_i && !flush_i;
        #2;
        if (ld && valid_o) begin
            if (sb.size() == 0) begin
                check("unexpected_delivery_pc", pc_o, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("deliv_pc", pc_o, e.pc);
                check("deliv_inst", inst_o, e.inst);
                check("deliv_ds", {31'd0, is_in_delayslot_o}, {31'd0, e.ds});
                check("deliv_exc", {31'd0, addr_exception_o}, {31'd0, e.exc});
            end
        end
    end

    initial begin
        exp_t e;
        rst = 1'b0; stall_i = 1'b0; flush_i = 1'b0; flush_pc_i = 32'h0;
        branch_flag_i = 1'b0; branch_to_addr_i = 32'h0; next_is_in_delayslot_i = 1'b0;
        inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b0; inst_rdata_i = 32'h0;

        // Reset values
        @(negedge clk); #1;
        check("rst_req", {31'd0, inst_req_o}, 32'd0);
        @(negedge clk); #1;
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_pc", pc_o, 32'h0);
        check("rst_inst", inst_o, 32'h0);
        check("rst_ds", {31'd0, is_in_delayslot_o}, 32'd0);
        check("rst_exc", {31'd0, addr_exception_o}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // First fetch straight out of reset
        fetch(fv(32'hBFC0_0000, 32'h3C01_BFC0, 0, 0, 0, 0, 0, 32'h0, 0));

        // Stall while data for BFC00004 returns: it lands in the hold buffer
        @(negedge clk);
        stall_i = 1'b1; inst_addr_ok_i = 1'b1; inst_data_ok_i = 1'b0;
        #1;
        check("stall_req", {31'd0, inst_req_o}, 32'd1);
        check("stall_addr", inst_addr_o, 32'hBFC0_0004);
        @(negedge clk);
        inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b1; inst_rdata_i = 32'h2421_0004;
        e.pc = 32'hBFC0_0004; e.inst = 32'h2421_0004; e.ds = 1'b0; e.exc = 1'b0;
        sb.push_back(e);
        #1;
        check("wait_req", {31'd0, inst_req_o}, 32'd0);
        @(negedge clk);
        inst_rdata_i = 32'hDEAD_BEEF;  // stray data_ok in HOLD must be ignored
        #1;
        check("hold_req", {31'd0, inst_req_o}, 32'd0);
        check("hold_pc", pc_o, 32'hBFC0_0000);
        check("hold_inst", inst_o, 32'h3C01_BFC0);
        check("hold_valid", {31'd0, valid_o}, 32'd1);
        @(negedge clk);
        stall_i = 1'b0; inst_data_ok_i = 1'b0;
        #1;
        check("hold_rel_req", {31'd0, inst_req_o}, 32'd0);

        // Straight-line fetches, then a branch with direct delay-slot tagging
        fetch(fv(32'hBFC0_0008, 32'h8C02_0008, 0, 0, 0, 0, 0, 32'h0, 0));
        fetch(fv(32'hBFC0_000C, 32'h8C03_000C, 0, 0, 0, 0, 0, 32'h0, 0));
        fetch(fv(32'hBFC0_0010, 32'h1000_003B, 0, 0, 0, 0, 0, 32'h0, 0));
        fetch(fv(32'hBFC0_0014, 32'h2484_0014, 1, 1, 1, 1, 1, 32'hBFC0_0100, 1));
        fetch(fv(32'hBFC0_0100, 32'h24A5_0100, 0, 0, 0, 0, 0, 32'h0, 0));
        // Branch consumed one cycle before the delay slot arrives: pending path
        fetch(fv(32'hBFC0_0104, 32'h1000_003F, 0, 0, 0, 0, 0, 32'h0, 0));
        fetch(fv(32'hBFC0_0108, 32'h24C6_0108, 0, 1, 1, 0, 0, 32'hBFC0_0200, 1));

        // Flush during WAIT: response is dropped, fetch resumes at the flush target
        @(negedge clk);
        branch_flag_i = 1'b0; next_is_in_delayslot_i = 1'b0;
        inst_addr_ok_i = 1'b1; inst_data_ok_i = 1'b0;
        #1;
        check("fl_req", {31'd0, inst_req_o}, 32'd1);
        check("fl_addr", inst_addr_o, 32'hBFC0_0200);
        @(negedge clk);
        inst_addr_ok_i = 1'b0; flush_i = 1'b1; flush_pc_i = 32'hBFC0_0380;
        @(negedge clk);
        flush_i = 1'b0; inst_data_ok_i = 1'b1; inst_rdata_i = 32'hBAD0_0200;
        #1;
        check("fl_valid", {31'd0, valid_o}, 32'd0);
        check("fl_discard_req", {31'd0, inst_req_o}, 32'd0);
        fetch(fv(32'hBFC0_0380, 32'h3C1A_BFC0, 0, 0, 0, 0, 0, 32'h0, 0));

        // Branch to a misaligned target: exception delivered without a bus access
        fetch(fv(32'hBFC0_0384, 32'h1000_0000, 0, 0, 0, 0, 0, 32'h0, 0));
        fetch(fv(32'hBFC0_0388, 32'h24E7_0388, 1, 1, 1, 1, 1, 32'hBFC0_0102, 1));
        @(negedge clk);
        branch_flag_i = 1'b0; next_is_in_delayslot_i = 1'b0; inst_data_ok_i = 1'b0;
        e.pc = 32'hBFC0_0102; e.inst = 32'h0; e.ds = 1'b0; e.exc = 1'b1;
        sb.push_back(e);
        #1;
        check("mis_req", {31'd0, inst_req_o}, 32'd0);
        @(negedge clk);
        flush_i = 1'b1; flush_pc_i = 32'hBFC0_0500;
        #1;
        check("mis2_req", {31'd0, inst_req_o}, 32'd0);

        // Reset in WAIT, stale data_ok after release must be ignored
        @(negedge clk);
        flush_i = 1'b0; inst_addr_ok_i = 1'b1;
        #1;
        check("pre_rst_addr", inst_addr_o, 32'hBFC0_0500);
        check("pre_rst_exc", {31'd0, addr_exception_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0; inst_addr_ok_i = 1'b0;
        #1;
        check("rst2_req", {31'd0, inst_req_o}, 32'd0);
        @(negedge clk);
        #1;
        check("rst2_valid", {31'd0, valid_o}, 32'd0);
        check("rst2_pc", pc_o, 32'h0);
        check("rst2_inst", inst_o, 32'h0);
        @(negedge clk);
        rst = 1'b1; inst_data_ok_i = 1'b1; inst_rdata_i = 32'hBAD0_0500;
        #1;
        check("stale_req", {31'd0, inst_req_o}, 32'd1);
        check("stale_addr", inst_addr_o, 32'hBFC0_0000);
        @(negedge clk);
        inst_data_ok_i = 1'b0;
        #1;
        check("stale_valid", {31'd0, valid_o}, 32'd0);
        check("stale_addr2", inst_addr_o, 32'hBFC0_0000);
        fetch(fv(32'hBFC0_0000, 32'h3C01_BFC0, 0, 0, 0, 0, 0, 32'h0, 0));

        idle();
        idle();
        idle();
        check("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the MIPS core; feeds the decode stage directly upstream.
- Owns the fetch PC and drives an SRAM-like instruction bus (req/addr_ok/data_ok) with one request outstanding at a time.
- Applies branch redirects and delay-slot tagging from decode, and flush/redirect from the exception unit.
- Flags misaligned fetch addresses without issuing a bus access.

Parameters:
RESET_PC, 32'hBFC0_0000, fetch address after reset
NOP_INST, 32'h0000_0000, instruction word driven on bubbles and on address exceptions

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-low (0 = reset)
stall_i  in  1  decode or a later stage holds; IF/ID register must not change
flush_i  in  1  exception/eret flush
flush_pc_i  in  32  redirect target used with flush_i
branch_flag_i  in  1  decode: the instruction now in ID is a taken branch/jump
branch_to_addr_i  in  32  decode: branch target
next_is_in_delayslot_i  in  1  decode: the instruction now in ID is a branch, so the next one is a delay slot
inst_req_o  out  1  bus request
inst_addr_o  out  32  bus address; stable while inst_req_o=1
inst_addr_ok_i  in  1  bus accepted the address
inst_data_ok_i  in  1  bus read data valid
inst_rdata_i  in  32  bus read data
pc_o  out  32  IF/ID: pc of the instruction
inst_o  out  32  IF/ID: instruction word
is_in_delayslot_o  out  1  IF/ID: instruction is a delay slot
addr_exception_o  out  1  IF/ID: fetch address misaligned
valid_o  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (rst=0 at posedge):
  - state=REQ, fetch_pc=RESET_PC, redir_pending=0, ds_pending=0.
  - pc_o=0, inst_o=NOP_INST, valid_o=0, is_in_delayslot_o=0, addr_exception_o=0.
  - inst_req_o=0 while rst=0.
- Consume/deliver rule:
  - "ID consumes" = !stall_i.
  - "Deliver X" = load X into IF/ID; only allowed when !stall_i.
  - If !stall_i and nothing is delivered, IF/ID loads a bubble: valid_o=0, inst_o=NOP_INST, addr_exception_o=0.
  - If stall_i=1, IF/ID holds its value.
- States:
  - REQ:
    - If fetch_pc[1:0]!=0: inst_req_o=0. When !stall_i, deliver {fetch_pc, NOP_INST, addr_exception=1}; stay in REQ.
    - Otherwise inst_req_o=1 and inst_addr_o=fetch_pc. addr_ok -> WAIT.
  - WAIT:
    - inst_req_o=0.
    - On data_ok with !stall_i: deliver, go to REQ.
    - On data_ok with stall_i: capture into the hold buffer, go to HOLD.
  - HOLD: when !stall_i, deliver the buffer, go to REQ.
  - DISCARD: wait for data_ok, drop the data, go to REQ.
- data_ok is honoured only in WAIT and DISCARD; in REQ/HOLD it is ignored (covers stale responses after reset).
- Next fetch PC, computed on every delivery of instruction X:
  - If valid_o && branch_flag_i: branch_to_addr_i.
  - Else if redir_pending: redir_target.
  - Else X.pc+4.
  - redir_pending clears on delivery.
- Delay slots:
  - X.is_in_delayslot = (valid_o && next_is_in_delayslot_i) | ds_pending; ds_pending clears on delivery.
  - If ID consumes a branch (valid_o && !stall_i) without a delivery in that cycle: set redir_pending/redir_target (if branch_flag_i) and ds_pending (if next_is_in_delayslot_i).
- Flush (highest priority, any state):
  - fetch_pc <= flush_pc_i; redir_pending=0, ds_pending=0; hold buffer dropped.
  - IF/ID loads a bubble regardless of stall_i.
  - REQ without addr_ok: request withdrawn -> REQ.
  - REQ with addr_ok, or WAIT without data_ok: -> DISCARD.
  - WAIT with data_ok, or HOLD: -> REQ.
  - DISCARD: stays DISCARD until data_ok.
- Arithmetic: pc+4 is 32-bit, wraps modulo 2^32, no exception on wrap.
- Bus timing: data_ok arrives at the earliest one cycle after addr_ok.

Test Plan:
- Reset release; addr_ok in the same cycle; data_ok=1 with rdata=32'h3C01BFC0 one cycle later, stall_i=0 -> inst_addr_o=BFC00000; next cycle valid_o=1, pc_o=BFC00000, inst_o=3C01BFC0; next inst_addr_o=BFC00004.
- stall_i=1 while data_ok arrives for BFC00004 -> IF/ID keeps the BFC00000 contents and inst_req_o stays 0. Release stall -> pc_o=BFC00004 delivered one cycle later, then request BFC00008.
- Branch at BFC00010 taken to BFC00100 -> BFC00014 delivered with is_in_delayslot_o=1, next inst_addr_o=BFC00100, BFC00018 never requested. Repeat with a one-cycle bubble between branch and delay slot -> same result via the pending path.
- flush_i with flush_pc_i=BFC00380 while in WAIT -> valid_o=0 the next cycle, the returning data_ok is dropped, next inst_addr_o=BFC00380.
- Branch target BFC00102 -> no inst_req_o; delivered pc_o=BFC00102, inst_o=0, addr_exception_o=1, valid_o=1.
- rst=0 during WAIT, then a stale data_ok after release -> all outputs back to reset values, stale data ignored, first request is BFC00000.
